// File: rtl/var_cmd_sequencer.sv
// var_cmd_sequencer
//   Host-side initiator for the variable register selector. Pops 32-bit command
//   words from a first-word-fall-through command FIFO and turns them into write
//   strobes or readback cycles on the selector bus. Readback words are pushed
//   into the response FIFO.
//
//   Header word: [31:28] op (1=WRITE, 2=READ, 0=NOP), [15:8] cnt (N=cnt+1),
//   [7:0] base. Word i of a burst targets (base+i) mod 256.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   cmd_data/valid    command FIFO head word (FWFT) and its valid flag
//   cmd_ready         pop strobe, word consumed when cmd_valid & cmd_ready
//   var_wr_en         selector write enable, high only while strobing
//   var_address       selector address, bits [31:8] always 0
//   var_value_out     selector write data
//   var_value_in      selector read data (combinational from the selector)
//   rsp_data/valid    response word, held until rsp_ready
//   rsp_ready         response FIFO not full
//   busy              high whenever the sequencer is not idle
//   err_count         saturating count of illegal addresses and bad opcodes
//
// Configuration
//   VAR_CMD_WRITE_ACK_EN  when defined, every WRITE burst ends by pushing one
//                         ack word {4'hA, 4'h0, errors, cnt, last addr}.

`timescale 1ns/1ps

module var_cmd_sequencer #(
  parameter int unsigned MAX_ADDR    = 46,
  parameter int unsigned WR_PULSE    = 2,
  parameter int unsigned READ_SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic        var_wr_en,
  output logic [31:0] var_address,
  output logic [31:0] var_value_out,
  input  logic [31:0] var_value_in,
  output logic [31:0] rsp_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        busy,
  output logic [15:0] err_count
);

  localparam int unsigned CNT_W = 16;
  localparam logic [3:0]  OP_NOP   = 4'h0;
  localparam logic [3:0]  OP_WRITE = 4'h1;
  localparam logic [3:0]  OP_READ  = 4'h2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_WR_DATA,
    S_WR_SETUP,
    S_WR_STROBE,
    S_WR_HOLD,
    S_RD_SETUP,
    S_RD_WAIT,
    S_RD_PUSH
  } state_t;

  state_t             r_state;
  logic               r_cmd_ready;
  logic               r_var_wr_en;
  logic [7:0]         r_var_address;
  logic [31:0]        r_var_value_out;
  logic [31:0]        r_rsp_data;
  logic               r_rsp_valid;
  logic               r_busy;
  logic [15:0]        r_err_count;
  logic [3:0]         r_op;
  logic [7:0]         r_cnt;
  logic [7:0]         r_addr;     // address of the word currently being sequenced
  logic [7:0]         r_left;     // words remaining after the current one
  logic [CNT_W-1:0]   r_pulse;
  logic [CNT_W-1:0]   r_settle;
`ifdef VAR_CMD_WRITE_ACK_EN
  logic [7:0]         r_cmd_err;  // errors seen within the current WRITE burst
`endif

  logic               w_cmd_pop;
  logic               w_addr_ok;
  logic               w_unused;

  assign w_cmd_pop = cmd_valid & r_cmd_ready;
  assign w_addr_ok = (32'(r_addr) <= MAX_ADDR);
  // Header bits [27:16] carry no meaning for this block.
  assign w_unused  = ^cmd_data[27:16];

  assign cmd_ready     = r_cmd_ready;
  assign var_wr_en     = r_var_wr_en;
  assign var_address   = {24'h0, r_var_address};
  assign var_value_out = r_var_value_out;
  assign rsp_data      = r_rsp_data;
  assign rsp_valid     = r_rsp_valid;
  assign busy          = r_busy;
  assign err_count     = r_err_count;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

`ifdef VAR_CMD_WRITE_ACK_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
`endif

  // Command sequencer: one registered FSM driving every output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_cmd_ready     <= 1'b0;
      r_var_wr_en     <= 1'b0;
      r_var_address   <= 8'h00;
      r_var_value_out <= 32'h0;
      r_rsp_data      <= 32'h0;
      r_rsp_valid     <= 1'b0;
      r_busy          <= 1'b0;
      r_err_count     <= 16'h0;
      r_op            <= 4'h0;
      r_cnt           <= 8'h00;
      r_addr          <= 8'h00;
      r_left          <= 8'h00;
      r_pulse         <= '0;
      r_settle        <= '0;
`ifdef VAR_CMD_WRITE_ACK_EN
      r_cmd_err       <= 8'h00;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          // cmd_ready comes up one cycle after reset, then stays high while idle.
          r_cmd_ready <= 1'b1;
          if (w_cmd_pop) begin
            r_op        <= cmd_data[31:28];
            r_cnt       <= cmd_data[15:8];
            r_addr      <= cmd_data[7:0];
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_HDR;
          end
        end

        S_HDR: begin
          r_left <= r_cnt;
`ifdef VAR_CMD_WRITE_ACK_EN
          r_cmd_err <= 8'h00;
`endif
          case (r_op)
            OP_WRITE: begin
              r_cmd_ready <= 1'b1;
              r_state     <= S_WR_DATA;
            end
            OP_READ: begin
              r_var_address <= r_addr;
              r_state       <= S_RD_SETUP;
            end
            OP_NOP: begin
              r_cmd_ready <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= S_IDLE;
            end
            default: begin
              r_err_count <= sat_inc16(r_err_count);
              r_cmd_ready <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= S_IDLE;
            end
          endcase
        end

        S_WR_DATA: begin
          if (w_cmd_pop) begin
            r_cmd_ready     <= 1'b0;
            r_var_address   <= r_addr;
            r_var_value_out <= cmd_data;
            if (w_addr_ok) begin
              r_state <= S_WR_SETUP;
            end else begin
              // Illegal address: word is consumed but skips the strobe.
              r_err_count <= sat_inc16(r_err_count);
`ifdef VAR_CMD_WRITE_ACK_EN
              r_cmd_err   <= sat_inc8(r_cmd_err);
`endif
              r_state     <= S_WR_HOLD;
            end
          end
        end

        S_WR_SETUP: begin
          r_var_wr_en <= 1'b1;
          r_pulse     <= '0;
          r_state     <= S_WR_STROBE;
        end

        S_WR_STROBE: begin
          if (r_pulse == CNT_W'(WR_PULSE - 1)) begin
            r_var_wr_en <= 1'b0;
            r_state     <= S_WR_HOLD;
          end else begin
            r_pulse <= r_pulse + CNT_W'(1);
          end
        end

        S_WR_HOLD: begin
          if (r_left == 8'h00) begin
`ifdef VAR_CMD_WRITE_ACK_EN
            // Ack goes out through the same handshake state as readback data.
            r_rsp_data  <= {4'hA, 4'h0, r_cmd_err, r_cnt, r_addr};
            r_rsp_valid <= 1'b1;
            r_state     <= S_RD_PUSH;
`else
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
`endif
          end else begin
            r_left      <= r_left - 8'd1;
            r_addr      <= r_addr + 8'd1;
            r_cmd_ready <= 1'b1;
            r_state     <= S_WR_DATA;
          end
        end

        S_RD_SETUP: begin
          r_settle <= '0;
          r_state  <= S_RD_WAIT;
        end

        S_RD_WAIT: begin
          if (r_settle == CNT_W'(READ_SETTLE - 1)) begin
            r_rsp_valid <= 1'b1;
            if (w_addr_ok) begin
              r_rsp_data <= var_value_in;
            end else begin
              r_rsp_data  <= {16'hDEAD, 8'h00, r_addr};
              r_err_count <= sat_inc16(r_err_count);
            end
            r_state <= S_RD_PUSH;
          end else begin
            r_settle <= r_settle + CNT_W'(1);
          end
        end

        S_RD_PUSH: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (r_left == 8'h00) begin
              r_cmd_ready <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= S_IDLE;
            end else begin
              r_left        <= r_left - 8'd1;
              r_addr        <= r_addr + 8'd1;
              r_var_address <= r_addr + 8'd1;
              r_state       <= S_RD_SETUP;
            end
          end
        end

        default: begin
          r_var_wr_en <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_var_cmd_sequencer.sv
// tb_var_cmd_sequencer
//   Directed bench for var_cmd_sequencer: a queue plays the FWFT command FIFO,
//   a 256-entry array plays the variable selector, and strobes and accepted
//   responses are logged for comparison against hand-computed values.

`timescale 1ns/1ps

module tb_var_cmd_sequencer;

  logic        clk;
  logic        rst;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        var_wr_en;
  logic [31:0] var_address;
  logic [31:0] var_value_out;
  logic [31:0] var_value_in;
  logic [31:0] rsp_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        busy;
  logic [15:0] err_count;

  int n_vec = 0;
  int n_mis = 0;

  logic [31:0] cmd_q [$];
  logic [31:0] rsp_q [$];
  logic [31:0] s_addr [$];
  logic [31:0] s_val [$];
  int          s_w [$];
  logic [31:0] mem [256];

  logic        prev_we = 1'b0;
  logic [31:0] cur_a   = 32'h0;
  logic [31:0] cur_v   = 32'h0;
  int          cur_w   = 0;

  var_cmd_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_data      (cmd_data),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .var_wr_en     (var_wr_en),
    .var_address   (var_address),
    .var_value_out (var_value_out),
    .var_value_in  (var_value_in),
    .rsp_data      (rsp_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .busy          (busy),
    .err_count     (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Selector model: combinational readback of the addressed variable.
  always_comb var_value_in = mem[var_address[7:0]];

  // FWFT FIFO head presentation.
  always @(negedge clk) begin
    cmd_valid = (cmd_q.size() != 0);
    cmd_data  = (cmd_q.size() != 0) ? cmd_q[0] : 32'h0;
  end

  // Edge-side bookkeeping: FIFO pop, selector write, strobe and response logs.
  always @(posedge clk) begin
    if (cmd_valid && cmd_ready && cmd_q.size() > 0) void'(cmd_q.pop_front());
    if (var_wr_en) mem[var_address[7:0]] = var_value_out;
    if (var_wr_en && !prev_we) begin
      cur_a = var_address;
      cur_v = var_value_out;
      cur_w = 1;
    end else if (var_wr_en) begin
      cur_w = cur_w + 1;
    end
    if (!var_wr_en && prev_we) begin
      s_addr.push_back(cur_a);
      s_val.push_back(cur_v);
      s_w.push_back(cur_w);
    end
    prev_we = var_wr_en;
    if (rsp_valid && rsp_ready) rsp_q.push_back(rsp_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    cmd_q.push_back(w);
  endtask

  task automatic clear_logs();
    s_addr.delete();
    s_val.delete();
    s_w.delete();
    rsp_q.delete();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (cmd_q.size() != 0 || busy || rsp_valid) begin
      @(negedge clk);
      n++;
      if (n > 2000) begin
        check({tag, "_timeout"}, 32'd1, 32'd0);
        return;
      end
    end
  endtask

  task automatic check_strobe(input string tag, input int idx, input logic [31:0] a,
                              input logic [31:0] v);
    if (idx < s_addr.size()) begin
      check({tag, "_addr"},  s_addr[idx], a);
      check({tag, "_value"}, s_val[idx],  v);
      check({tag, "_width"}, 32'(s_w[idx]), 32'd2);
    end else begin
      check({tag, "_missing"}, 32'(s_addr.size()), 32'(idx + 1));
    end
  endtask

  task automatic check_rsp(input string tag, input int idx, input logic [31:0] v);
    if (idx < rsp_q.size()) check(tag, rsp_q[idx], v);
    else check({tag, "_missing"}, 32'(rsp_q.size()), 32'(idx + 1));
  endtask

  initial begin
    logic [31:0] d0;
    logic [31:0] exp3 [3];
    int stall_bad;
    int pop_bad;
    int n;

    rst       = 1'b1;
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[45] = 32'h1234_5678;
    mem[46] = 32'h0BAD_F00D;

    // Reset state
    #3;
    check("rst_cmd_ready", 32'(cmd_ready),   32'd0);
    check("rst_wr_en",     32'(var_wr_en),   32'd0);
    check("rst_address",   var_address,      32'd0);
    check("rst_value_out", var_value_out,    32'd0);
    check("rst_rsp_data",  rsp_data,         32'd0);
    check("rst_rsp_valid", 32'(rsp_valid),   32'd0);
    check("rst_busy",      32'(busy),        32'd0);
    check("rst_err",       32'(err_count),   32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: single write to addr 2, then read it back
    push(32'h1000_0002);
    push(32'h0000_1388);
    wait_idle("t1_wr");
    check("t1_nstrobe", 32'(s_addr.size()), 32'd1);
    check_strobe("t1_s0", 0, 32'd2, 32'd5000);
    clear_logs();
    push(32'h2000_0002);
    wait_idle("t1_rd");
    check("t1_nrsp", 32'(rsp_q.size()), 32'd1);
    check_rsp("t1_rsp0", 0, 32'h0000_1388);
    check("t1_rd_nostrobe", 32'(s_addr.size()), 32'd0);

    // 2: burst write 10..12, then burst read back
    clear_logs();
    push(32'h1000_020A);
    push(32'd13);
    push(32'd5);
    push(32'd100);
    wait_idle("t2_wr");
    check("t2_nstrobe", 32'(s_addr.size()), 32'd3);
    check_strobe("t2_s0", 0, 32'd10, 32'd13);
    check_strobe("t2_s1", 1, 32'd11, 32'd5);
    check_strobe("t2_s2", 2, 32'd12, 32'd100);
`ifdef VAR_CMD_WRITE_ACK_EN
    check("t2_nack", 32'(rsp_q.size()), 32'd1);
    check_rsp("t2_ack", 0, 32'hA000_020C);
`else
    check("t2_nack", 32'(rsp_q.size()), 32'd0);
`endif
    clear_logs();
    push(32'h2000_020A);
    wait_idle("t2_rd");
    check("t2_nrsp", 32'(rsp_q.size()), 32'd3);
    exp3[0] = 32'd13;
    exp3[1] = 32'd5;
    exp3[2] = 32'd100;
    for (int i = 0; i < 3; i++) check_rsp($sformatf("t2_rsp%0d", i), i, exp3[i]);
    check("t2_err", 32'(err_count), 32'd0);

    // 3: read across MAX_ADDR, write wrapping past 255
    clear_logs();
    push(32'h2000_022D);
    wait_idle("t3_rd");
    check("t3_nrsp", 32'(rsp_q.size()), 32'd3);
    exp3[0] = 32'h1234_5678;
    exp3[1] = 32'h0BAD_F00D;
    exp3[2] = 32'hDEAD_002F;
    for (int i = 0; i < 3; i++) check_rsp($sformatf("t3_rsp%0d", i), i, exp3[i]);
    check("t3_err_rd", 32'(err_count), 32'd1);
    clear_logs();
    push(32'h1000_01FF);
    push(32'h0000_0011);
    push(32'h0000_0022);
    wait_idle("t3_wr");
    check("t3_nstrobe", 32'(s_addr.size()), 32'd1);
    check_strobe("t3_s0", 0, 32'd0, 32'h22);
    check("t3_err_wr", 32'(err_count), 32'd2);
    check("t3_last_addr", var_address, 32'd0);
    check("t3_last_value", var_value_out, 32'h22);
`ifdef VAR_CMD_WRITE_ACK_EN
    check("t3_nack", 32'(rsp_q.size()), 32'd1);
    check_rsp("t3_ack", 0, 32'hA001_0100);
`else
    check("t3_nack", 32'(rsp_q.size()), 32'd0);
`endif

    // 4: response backpressure, then a bad opcode
    clear_logs();
    rsp_ready = 1'b0;
    push(32'h2000_0002);
    push(32'h0000_0000);
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t4_rsp_valid_seen", 32'(rsp_valid), 32'd1);
    d0 = rsp_data;
    check("t4_rsp_data", d0, 32'h0000_1388);
    stall_bad = 0;
    pop_bad   = 0;
    repeat (20) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== d0) stall_bad++;
      if (cmd_q.size() != 1) pop_bad++;
    end
    check("t4_stall_hold", 32'(stall_bad), 32'd0);
    check("t4_no_pop", 32'(pop_bad), 32'd0);
    rsp_ready = 1'b1;
    wait_idle("t4_rd");
    check("t4_nrsp", 32'(rsp_q.size()), 32'd1);
    check_rsp("t4_rsp0", 0, 32'h0000_1388);
    check("t4_err_nop", 32'(err_count), 32'd2);
    push(32'h7000_0000);
    wait_idle("t4_bad");
    check("t4_err_bad", 32'(err_count), 32'd3);

    // 5: reset during the write strobe
    clear_logs();
    push(32'h1000_0003);
    push(32'h0000_0055);
    n = 0;
    while (!var_wr_en && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t5_strobe_seen", 32'(var_wr_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_wr_en",     32'(var_wr_en),  32'd0);
    check("t5_busy",      32'(busy),       32'd0);
    check("t5_cmd_ready", 32'(cmd_ready),  32'd0);
    check("t5_address",   var_address,     32'd0);
    check("t5_value_out", var_value_out,   32'd0);
    check("t5_rsp_valid", 32'(rsp_valid),  32'd0);
    check("t5_err",       32'(err_count),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_idle_ready", 32'(cmd_ready), 32'd1);
    check("t5_idle_busy",  32'(busy),      32'd0);
    push(32'h1000_0004);
    push(32'h0000_CAFE);
    wait_idle("t5_wr");
    clear_logs();
    push(32'h2000_0004);
    wait_idle("t5_rd");
    check("t5_nrsp", 32'(rsp_q.size()), 32'd1);
    check_rsp("t5_rsp0", 0, 32'h0000_CAFE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
